ovf_range_cbuf: RTL and testbench
=================================

Name: ovf_range_cbuf

Overview:
Circular store of detected heap-overflow address ranges. It sits directly downstream of the bop unit: it accepts a registered write request carrying a [first,last] range once an overflow run is closed. It answers same-cycle range lookups that the bop unit uses to flag loads inside overflowed regions and to detect read overflows for the dataleak check. Oldest entries are overwritten when the store is full.

Parameters:
DEPTH, 8, number of range entries (power of two, >=2)
AW, 32, address width

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
clear_i  input  1  soft clear of all entries (user-level reset)
wr_en_i  input  1  write request, one-cycle pulse per range
wr_first_i  input  AW  first byte address of range
wr_last_i  input  AW  last byte address of range
find_addr_i  input  AW  lookup address (load/store vaddr)
base_addr_i  input  AW  base address of current consecutive-read run
addr_in_range_o  output  1  find_addr_i lies inside a valid entry
hit_idx_o  output  $clog2(DEPTH)  lowest matching entry index
read_o  output  AW  first address of most recently written/updated entry
read2_o  output  AW  last address of most recently written/updated entry
read_overflow_o  output  1  read run from base_addr_i crosses into a stored range
count_o  output  $clog2(DEPTH+1)  number of valid entries
wr_drop_o  output  1  one-cycle pulse: write rejected (first > last)
evict_o  output  1  one-cycle pulse: valid oldest entry overwritten

Behaviour:
- Storage: per entry valid, first, last; write pointer wp; count.
- Reset (rst_i=1 at clk edge): all valid=0; wp=0; count=0; read_o=read2_o=0; wr_drop_o=evict_o=0. Combinational outputs are therefore 0 after reset.
- clear_i: same effect as reset on the next edge. Priority is rst_i > clear_i > wr_en_i. A write in the clear cycle is discarded.
- Write, wr_en_i=1, wr_first_i<=wr_last_i, without merge:
  - entry[wp] <= {1, first, last}.
  - wp <= wp+1, modulo DEPTH (wraps DEPTH-1 to 0).
  - If entry[wp] was valid, pulse evict_o and leave count unchanged; else count+1.
  - read_o/read2_o <= written first/last.
- Write with wr_first_i > wr_last_i: no state change; wr_drop_o=1 for one cycle.
- Latency: a write becomes visible to lookups on the cycle after the write edge. A lookup in the write cycle sees the old contents.
- Lookup (combinational):
  - match[i] = valid[i] && first[i] <= find_addr_i <= last[i], unsigned compare, inclusive both ends.
  - addr_in_range_o = OR of match.
  - hit_idx_o = lowest i with match[i], or 0 if there is no match.
- read_overflow_o (combinational): 1 if any valid i has base_addr_i < first[i] and find_addr_i >= first[i] (unsigned).
- Outputs are not registered. The consumer registers them.
- Address arithmetic is unsigned AW-bit. last+1 used in merge checks is computed at AW+1 bits, so last=all-ones does not wrap to 0.

Optional Feature:
Macro OVF_CBUF_MERGE_EN.
- Defined: on a legal write, if any valid entry i satisfies wr_first_i <= last[i]+1 and wr_last_i+1 >= first[i] (overlap or adjacency):
  - the lowest such i is widened to first=min, last=max;
  - wp, count and evict_o are unchanged;
  - read_o/read2_o <= the widened bounds of entry i.
  - Only one entry merges per write. Other overlapping entries stay as they are.
- Undefined: every legal write allocates at wp as above.

Test Plan:
- Reset, then find_addr_i=0x1000 -> addr_in_range_o=0, count_o=0, read_o=0, read2_o=0, read_overflow_o=0.
- Write [0x1000,0x1027]; next cycle find 0x1000, 0x1027, 0x1028 -> 1, 1, 0; hit_idx_o=0; read_o=0x1000; read2_o=0x1027; count_o=1. In the write cycle itself, find 0x1000 -> 0.
- DEPTH=8: write 9 disjoint ranges base 0x100*k, len 0x40 -> 9th write pulses evict_o; count_o=8; range k=0 no longer hits; range k=8 hits with hit_idx_o=0.
- Write first=0x2000, last=0x1FFF -> wr_drop_o=1 for one cycle; count_o unchanged. Assert clear_i together with wr_en_i -> count_o=0 and no entry valid next cycle.
- Stored [0x3000,0x303F], base_addr_i=0x2FF0: find 0x3000 -> read_overflow_o=1; find 0x2FFF -> 0. With base_addr_i=0x3000 and find 0x3010 -> 0.
- With OVF_CBUF_MERGE_EN: stored [0x4000,0x400F], write [0x4010,0x401F] -> count_o stays 1; read_o=0x4000; read2_o=0x401F; find 0x401F hits. Without the macro -> count_o=2.

Source files
------------

// File: rtl/ovf_range_cbuf.sv
// Circular store of heap-overflow address ranges with same-cycle range lookup.
// Optional feature: define OVF_CBUF_MERGE_EN to widen an overlapping/adjacent entry instead of allocating.
module ovf_range_cbuf #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       wr_en_i,
  input  logic [AW-1:0]              wr_first_i,
  input  logic [AW-1:0]              wr_last_i,
  input  logic [AW-1:0]              find_addr_i,
  input  logic [AW-1:0]              base_addr_i,
  output logic                       addr_in_range_o,
  output logic [$clog2(DEPTH)-1:0]   hit_idx_o,
  output logic [AW-1:0]              read_o,
  output logic [AW-1:0]              read2_o,
  output logic                       read_overflow_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       wr_drop_o,
  output logic                       evict_o
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]    first_q [DEPTH];
  logic [AW-1:0]    first_d [DEPTH];
  logic [AW-1:0]    last_q  [DEPTH];
  logic [AW-1:0]    last_d  [DEPTH];
  logic [IW-1:0]    wp_q, wp_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    read_q, read_d;
  logic [AW-1:0]    read2_q, read2_d;
  logic             wr_drop_q, wr_drop_d;
  logic             evict_q, evict_d;

  logic             wr_legal;
  logic [DEPTH-1:0] match;
  logic             hit;
  logic [IW-1:0]    hit_idx;
  logic             rd_ovf;

  assign wr_legal = wr_en_i && (wr_first_i <= wr_last_i);

  // Lookup: inclusive range match, lowest index wins.
  always_comb begin
    match   = '0;
    hit     = 1'b0;
    hit_idx = '0;
    rd_ovf  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid_q[i] && (first_q[i] <= find_addr_i) && (find_addr_i <= last_q[i]);
      if (valid_q[i] && (base_addr_i < first_q[i]) && (find_addr_i >= first_q[i])) begin
        rd_ovf = 1'b1;
      end
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

`ifdef OVF_CBUF_MERGE_EN
  logic          merge_hit;
  logic [IW-1:0] merge_idx;
  logic [AW-1:0] merge_first;
  logic [AW-1:0] merge_last;

  // Overlap/adjacency uses AW+1-bit sums so an all-ones bound does not wrap.
  always_comb begin
    merge_hit = 1'b0;
    merge_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] &&
          ({1'b0, wr_first_i} <= ({1'b0, last_q[i]} + (AW+1)'(1))) &&
          (({1'b0, wr_last_i} + (AW+1)'(1)) >= {1'b0, first_q[i]})) begin
        merge_hit = 1'b1;
        merge_idx = IW'(i);
      end
    end
    merge_first = (wr_first_i < first_q[merge_idx]) ? wr_first_i : first_q[merge_idx];
    merge_last  = (wr_last_i  > last_q[merge_idx])  ? wr_last_i  : last_q[merge_idx];
  end
`endif

  // Next-state: clear beats write; illegal write only raises the drop pulse.
  always_comb begin
    valid_d   = valid_q;
    first_d   = first_q;
    last_d    = last_q;
    wp_d      = wp_q;
    count_d   = count_q;
    read_d    = read_q;
    read2_d   = read2_q;
    wr_drop_d = 1'b0;
    evict_d   = 1'b0;
    if (clear_i) begin
      valid_d = '0;
      wp_d    = '0;
      count_d = '0;
      read_d  = '0;
      read2_d = '0;
    end else if (wr_en_i && !wr_legal) begin
      wr_drop_d = 1'b1;
    end else if (wr_legal) begin
`ifdef OVF_CBUF_MERGE_EN
      if (merge_hit) begin
        first_d[merge_idx] = merge_first;
        last_d[merge_idx]  = merge_last;
        read_d             = merge_first;
        read2_d            = merge_last;
      end else begin
`else
      begin
`endif
        valid_d[wp_q] = 1'b1;
        first_d[wp_q] = wr_first_i;
        last_d[wp_q]  = wr_last_i;
        wp_d          = wp_q + IW'(1);
        read_d        = wr_first_i;
        read2_d       = wr_last_i;
        if (valid_q[wp_q]) begin
          evict_d = 1'b1;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q   <= '0;
      wp_q      <= '0;
      count_q   <= '0;
      read_q    <= '0;
      read2_q   <= '0;
      wr_drop_q <= 1'b0;
      evict_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        first_q[i] <= '0;
        last_q[i]  <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      wp_q      <= wp_d;
      count_q   <= count_d;
      read_q    <= read_d;
      read2_q   <= read2_d;
      wr_drop_q <= wr_drop_d;
      evict_q   <= evict_d;
      for (int i = 0; i < DEPTH; i++) begin
        first_q[i] <= first_d[i];
        last_q[i]  <= last_d[i];
      end
    end
  end

  assign addr_in_range_o = hit;
  assign hit_idx_o       = hit_idx;
  assign read_overflow_o = rd_ovf;
  assign read_o          = read_q;
  assign read2_o         = read2_q;
  assign count_o         = count_q;
  assign wr_drop_o       = wr_drop_q;
  assign evict_o         = evict_q;

endmodule

// File: tb/tb_ovf_range_cbuf.sv
// Scoreboard bench for ovf_range_cbuf: directed vectors queue expectations, a negedge monitor compares.
module tb_ovf_range_cbuf;

  localparam logic [31:0] NOB = 32'hFFFF_FFFF;
  localparam logic [31:0] NOF = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst_i, clear_i, wr_en_i;
  logic [31:0] wr_first_i, wr_last_i, find_addr_i, base_addr_i;
  logic        addr_in_range_o, read_overflow_o, wr_drop_o, evict_o;
  logic [2:0]  hit_idx_o;
  logic [31:0] read_o, read2_o;
  logic [3:0]  count_o;

  always #5 clk = ~clk;

  ovf_range_cbuf #(.DEPTH(8), .AW(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .wr_en_i(wr_en_i),
    .wr_first_i(wr_first_i), .wr_last_i(wr_last_i), .find_addr_i(find_addr_i),
    .base_addr_i(base_addr_i), .addr_in_range_o(addr_in_range_o), .hit_idx_o(hit_idx_o),
    .read_o(read_o), .read2_o(read2_o), .read_overflow_o(read_overflow_o),
    .count_o(count_o), .wr_drop_o(wr_drop_o), .evict_o(evict_o)
  );

  typedef struct {
    string       name;
    logic        air;
    logic [2:0]  hit;
    logic        rov;
    logic [3:0]  cnt;
    logic [31:0] rd;
    logic [31:0] rd2;
    logic        drop;
    logic        ev;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  ex_cnt;
  logic [31:0] ex_rd, ex_rd2;
  logic [2:0]  hit_b, hit_c;

  task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%h required=%h", n, f, act, req);
    end
  endtask

  // One cycle of stimulus; expectation describes outputs observed during this cycle.
  task automatic vec(input string name, input logic wr, input logic [31:0] f, input logic [31:0] l,
                     input logic [31:0] fa, input logic [31:0] ba, input logic clr,
                     input logic air, input logic [2:0] hit, input logic rov,
                     input logic drop, input logic ev);
    exp_t e;
    clear_i     = clr;
    wr_en_i     = wr;
    wr_first_i  = f;
    wr_last_i   = l;
    find_addr_i = fa;
    base_addr_i = ba;
    e.name = name; e.air = air; e.hit = hit; e.rov = rov; e.cnt = ex_cnt;
    e.rd = ex_rd; e.rd2 = ex_rd2; e.drop = drop; e.ev = ev;
    sb.push_back(e);
    @(posedge clk);
    #1;
    clear_i = 1'b0;
    wr_en_i = 1'b0;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.name, "in_range", 32'(addr_in_range_o), 32'(e.air));
      chk(e.name, "hit_idx",  32'(hit_idx_o),       32'(e.hit));
      chk(e.name, "rd_ovf",   32'(read_overflow_o), 32'(e.rov));
      chk(e.name, "count",    32'(count_o),         32'(e.cnt));
      chk(e.name, "read",     read_o,               e.rd);
      chk(e.name, "read2",    read2_o,              e.rd2);
      chk(e.name, "wr_drop",  32'(wr_drop_o),       32'(e.drop));
      chk(e.name, "evict",    32'(evict_o),         32'(e.ev));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; wr_en_i = 1'b0;
    wr_first_i = '0; wr_last_i = '0; find_addr_i = '0; base_addr_i = NOB;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;

    ex_cnt = 0; ex_rd = 0; ex_rd2 = 0;
    vec("reset",   0, 0, 0, 32'h1000, 32'h0, 0, 0, 0, 0, 0, 0);
    vec("wr_cyc",  1, 32'h1000, 32'h1027, 32'h1000, NOB, 0, 0, 0, 0, 0, 0);
    ex_cnt = 1; ex_rd = 32'h1000; ex_rd2 = 32'h1027;
    vec("lo_edge", 0, 0, 0, 32'h1000, NOB, 0, 1, 0, 0, 0, 0);
    vec("hi_edge", 0, 0, 0, 32'h1027, NOB, 0, 1, 0, 0, 0, 0);
    vec("past_hi", 0, 0, 0, 32'h1028, NOB, 0, 0, 0, 0, 0, 0);
    vec("clr",     0, 0, 0, 32'h1000, NOB, 1, 1, 0, 0, 0, 0);
    ex_cnt = 0; ex_rd = 0; ex_rd2 = 0;
    vec("clr_after", 0, 0, 0, 32'h1000, NOB, 0, 0, 0, 0, 0, 0);

    // Nine disjoint ranges into eight slots; the ninth overwrites slot 0.
    for (int k = 0; k < 9; k++) begin
      ex_cnt = (k > 8) ? 4'd8 : 4'(k);
      ex_rd  = (k == 0) ? 32'h0 : 32'(k - 1) * 32'h100;
      ex_rd2 = (k == 0) ? 32'h0 : 32'(k - 1) * 32'h100 + 32'h3F;
      vec($sformatf("fill%0d", k), 1, 32'(k) * 32'h100, 32'(k) * 32'h100 + 32'h3F,
          NOF, NOB, 0, 0, 0, 0, 0, 0);
    end
    ex_cnt = 8; ex_rd = 32'h800; ex_rd2 = 32'h83F;
    vec("evicted",  0, 0, 0, 32'h0000, NOB, 0, 0, 0, 0, 0, 1);
    vec("new_slot0",0, 0, 0, 32'h0810, NOB, 0, 1, 0, 0, 0, 0);
    vec("slot7",    0, 0, 0, 32'h0710, NOB, 0, 1, 7, 0, 0, 0);
    vec("gap",      0, 0, 0, 32'h0140, NOB, 0, 0, 0, 0, 0, 0);
    vec("slot1_hi", 0, 0, 0, 32'h013F, NOB, 0, 1, 1, 0, 0, 0);

    vec("drop_wr",  1, 32'h2000, 32'h1FFF, NOF, NOB, 0, 0, 0, 0, 0, 0);
    vec("drop_pls", 0, 0, 0, NOF, NOB, 0, 0, 0, 0, 1, 0);
    vec("drop_end", 0, 0, 0, NOF, NOB, 0, 0, 0, 0, 0, 0);

    vec("clr_wr",   1, 32'h5000, 32'h5000, 32'h0810, NOB, 1, 1, 0, 0, 0, 0);
    ex_cnt = 0; ex_rd = 0; ex_rd2 = 0;
    vec("clr_old",  0, 0, 0, 32'h0810, NOB, 0, 0, 0, 0, 0, 0);
    vec("clr_new",  0, 0, 0, 32'h5000, NOB, 0, 0, 0, 0, 0, 0);

    vec("ovf_wr",   1, 32'h3000, 32'h303F, NOF, NOB, 0, 0, 0, 0, 0, 0);
    ex_cnt = 1; ex_rd = 32'h3000; ex_rd2 = 32'h303F;
    vec("ovf_in",   0, 0, 0, 32'h3000, 32'h2FF0, 0, 1, 0, 1, 0, 0);
    vec("ovf_below",0, 0, 0, 32'h2FFF, 32'h2FF0, 0, 0, 0, 0, 0, 0);
    vec("ovf_base", 0, 0, 0, 32'h3010, 32'h3000, 0, 1, 0, 0, 0, 0);
    vec("ovf_top",  0, 0, 0, 32'h303F, 32'h2FF0, 0, 1, 0, 1, 0, 0);

    vec("clr2",     0, 0, 0, NOF, NOB, 1, 0, 0, 0, 0, 0);
    ex_cnt = 0; ex_rd = 0; ex_rd2 = 0;
    vec("m_wr1",    1, 32'h4000, 32'h400F, NOF, NOB, 0, 0, 0, 0, 0, 0);
    ex_cnt = 1; ex_rd = 32'h4000; ex_rd2 = 32'h400F;
    vec("m_wr2",    1, 32'h4010, 32'h401F, 32'h4010, NOB, 0, 0, 0, 0, 0, 0);
`ifdef OVF_CBUF_MERGE_EN
    ex_cnt = 1; ex_rd = 32'h4000; ex_rd2 = 32'h401F; hit_b = 0;
`else
    ex_cnt = 2; ex_rd = 32'h4010; ex_rd2 = 32'h401F; hit_b = 1;
`endif
    vec("m_hit_hi", 0, 0, 0, 32'h401F, NOB, 0, 1, hit_b, 0, 0, 0);
    vec("m_wr_top", 1, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h400F, NOB, 0, 1, 0, 0, 0, 0);
`ifdef OVF_CBUF_MERGE_EN
    ex_cnt = 2; hit_c = 1;
`else
    ex_cnt = 3; hit_c = 2;
`endif
    ex_rd = 32'hFFFF_FFF0; ex_rd2 = 32'hFFFF_FFFF;
    vec("top_hit",  0, 0, 0, 32'hFFFF_FFFF, NOB, 0, 1, hit_c, 0, 0, 0);

    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
